// File: rtl/spm_ex_loader_pkg.sv
// spm_ex_loader_pkg: shared widths, ex_in_bus field offsets and FSM states for the scratchpad loader
package spm_ex_loader_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 8;
  localparam int NBANK      = 4;
  localparam int LEN_W      = 10;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int BK_W       = $clog2(NBANK);
  localparam int EX_IN_W    = 168;
  localparam int WEN_LSB    = 164;
  localparam int REN_LSB    = 160;
  localparam int ADDR_LSB   = 128;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_e;
endpackage

// File: rtl/spm_ex_loader_if.sv
// spm_ex_loader_if: command, write/read streams and scratchpad external port of the loader
interface spm_ex_loader_if;
  import spm_ex_loader_pkg::*;
  logic                    start;
  logic                    mode;
  logic [ADDR_W-1:0]       base_addr;
  logic [LEN_W-1:0]        len;
  logic [NBANK-1:0]        bank_mask;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    s_valid;
  logic [DATA_W-1:0]       s_data;
  logic                    s_ready;
  logic                    m_valid;
  logic [DATA_W-1:0]       m_data;
  logic                    m_ready;
  logic [NBANK*DATA_W-1:0] ex_out_bus;
  logic [EX_IN_W-1:0]      ex_in_bus;
  modport master (
    input  start, mode, base_addr, len, bank_mask, s_valid, s_data, m_ready, ex_out_bus,
    output busy, done, err, s_ready, m_valid, m_data, ex_in_bus
  );
  modport slave (
    output start, mode, base_addr, len, bank_mask, s_valid, s_data, m_ready, ex_out_bus,
    input  busy, done, err, s_ready, m_valid, m_data, ex_in_bus
  );
endinterface

// File: rtl/spm_rd_fifo.sv
// spm_rd_fifo: synchronous read-return FIFO; caller guarantees no push when full and no pop when empty
module spm_rd_fifo import spm_ex_loader_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = DATA_W,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wp_q] <= din_i;
      wp_q  <= wp_q + PW'(push_i);
      rp_q  <= rp_q + PW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
endmodule

// File: rtl/spm_ex_loader.sv
// spm_ex_loader: streams words to/from scratchpad banks round-robin over the enabled bank set
module spm_ex_loader import spm_ex_loader_pkg::*; (
  input logic              clk_i,
  input logic              rst_ni,
  spm_ex_loader_if.master  bus_if
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_e             state_q;
  logic [EX_IN_W-1:0] ex_q, ex_d;
  logic               busy_q, done_q, err_q, rej_q;
  logic [NBANK-1:0]   mask_q;
  logic [BK_W-1:0]    bank_q, eb_q, nb, hb;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [RD_LAT-1:0]  tv_q;
  logic [BK_W-1:0]    tb_q [RD_LAT];
  logic [CW-1:0]      fcnt;
  logic               s_rdy, beat_w, beat_r, beat, ren_any, room, drained, pop;
  function automatic logic [BK_W-1:0] next_bank(input logic [NBANK-1:0] m, input logic [BK_W-1:0] cur);
    logic [BK_W-1:0] n;
    next_bank = cur;
    for (int i = NBANK; i >= 1; i--) begin
      n = cur + BK_W'(i);
      if (m[n]) next_bank = n;
    end
  endfunction
  // in-flight reads are the ren currently on the bus plus every valid tag stage
  assign ren_any = |ex_q[REN_LSB +: NBANK];
  assign room    = $countones(tv_q) + int'(ren_any) + int'(fcnt) < FIFO_DEPTH;
  assign drained = !ren_any && tv_q == '0 && fcnt == '0;
  assign s_rdy   = state_q == WRITE && rem_q != '0;
  assign beat_w  = s_rdy && bus_if.s_valid;
  assign beat_r  = state_q == READ && rem_q != '0 && room;
  assign beat    = beat_w || beat_r;
  assign nb      = next_bank(mask_q, bank_q);
  assign hb      = tb_q[RD_LAT-1];
  assign pop     = bus_if.m_valid && bus_if.m_ready;
  always_comb begin
    ex_d = '0;
    if (beat) ex_d[ADDR_LSB + ADDR_W*int'(bank_q) +: ADDR_W] = addr_q;
    if (beat_w) ex_d[DATA_W*int'(bank_q) +: DATA_W] = bus_if.s_data;
    if (beat_w) ex_d[WEN_LSB + int'(bank_q)] = 1'b1;
    if (beat_r) ex_d[REN_LSB + int'(bank_q)] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      ex_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rej_q   <= 1'b0;
      mask_q  <= '0;
      bank_q  <= '0;
      eb_q    <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      tv_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) tb_q[i] <= '0;
    end else begin
      ex_q    <= ex_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tv_q[0] <= ren_any;
      tb_q[0] <= eb_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tv_q[i] <= tv_q[i-1];
        tb_q[i] <= tb_q[i-1];
      end
      // a wrap back to a lower-or-equal bank closes one pass over the enabled set
      if (beat) begin
        eb_q   <= bank_q;
        bank_q <= nb;
        addr_q <= addr_q + ADDR_W'(nb <= bank_q);
        rem_q  <= rem_q - 1'b1;
      end
      case (state_q)
        IDLE: if (bus_if.start) begin
          rej_q <= bus_if.len == '0 || bus_if.bank_mask == '0;
          if (bus_if.len == '0 || bus_if.bank_mask == '0) state_q <= FIN;
          else begin
            mask_q  <= bus_if.bank_mask;
            addr_q  <= bus_if.base_addr;
            rem_q   <= bus_if.len;
            bank_q  <= next_bank(bus_if.bank_mask, '1);
            busy_q  <= 1'b1;
            state_q <= bus_if.mode ? READ : WRITE;
          end
        end
        WRITE: if (beat_w && rem_q == 1) state_q <= FIN;
        READ:  if (beat_r && rem_q == 1) state_q <= DRAIN;
        DRAIN: if (drained) state_q <= FIN;
        FIN: begin
          done_q  <= 1'b1;
          err_q   <= rej_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  spm_rd_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tv_q[RD_LAT-1]),
    .din_i   (bus_if.ex_out_bus[DATA_W*int'(hb) +: DATA_W]),
    .pop_i   (pop),
    .dout_o  (bus_if.m_data),
    .count_o (fcnt)
  );
  assign bus_if.m_valid   = fcnt != '0;
  assign bus_if.ex_in_bus = ex_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.done      = done_q;
  assign bus_if.err       = err_q;
  assign bus_if.s_ready   = s_rdy;
endmodule

// File: tb/tb_spm_ex_loader.sv
// tb_spm_ex_loader: randomized scoreboard bench for spm_ex_loader against a beat-list reference model
module tb_spm_ex_loader;
  import spm_ex_loader_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spm_ex_loader_if bus();
  spm_ex_loader dut (.clk_i(clk), .rst_ni(rst_n), .bus_if(bus));
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0, n_ren = 0, first_ren = -1, last_ren = -1;
  logic [EX_IN_W-1:0] exp_ex [$];
  logic [DATA_W-1:0]  exp_m [$];
  logic               exp_done [$];
  logic [DATA_W-1:0]  wdata [$];
  logic [EX_IN_W-1:0] pend;
  always @(posedge clk) cyc++;
  task automatic check(string nm, logic [EX_IN_W-1:0] act, logic [EX_IN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_i(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic bad(string nm);
    checks++;
    failures++;
    $display("FAIL %s: event seen, none expected", nm);
  endtask
  function automatic logic [EX_IN_W-1:0] mk_bus(bit wr, int b, logic [7:0] a, logic [31:0] d);
    logic [EX_IN_W-1:0] v = '0;
    v[(wr ? WEN_LSB : REN_LSB) + b] = 1'b1;
    v[ADDR_LSB + 8*b +: 8] = a;
    if (wr) v[32*b +: 32] = d;
    return v;
  endfunction
  // reference: beat k hits the (k mod n)-th enabled bank at base + k div n
  task automatic model(bit md, logic [7:0] base, int ln, logic [3:0] mk, bit seq);
    int en [$];
    for (int b = 0; b < NBANK; b++) if (mk[b]) en.push_back(b);
    wdata.delete();
    if (ln == 0 || en.size() == 0) begin
      exp_done.push_back(1'b1);
      return;
    end
    for (int k = 0; k < ln; k++) begin
      int b = en[k % en.size()];
      logic [7:0] a = base + 8'(k / en.size());
      logic [31:0] d = seq ? 32'(k + 1) : $urandom;
      if (!md) begin
        wdata.push_back(d);
        exp_ex.push_back(mk_bus(1'b1, b, a, d));
      end else begin
        exp_ex.push_back(mk_bus(1'b0, b, a, '0));
        exp_m.push_back({16'hBEEF, 8'(b), a});
      end
    end
    exp_done.push_back(1'b0);
  endtask
  initial begin
    bus.ex_out_bus = '0;
    forever begin
      @(negedge clk);
      pend = bus.ex_in_bus;
      @(posedge clk);
      #1;
      for (int b = 0; b < NBANK; b++)
        bus.ex_out_bus[32*b +: 32] = pend[REN_LSB + b] ? {16'hBEEF, 8'(b), pend[ADDR_LSB + 8*b +: 8]} : $urandom;
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (bus.ex_in_bus != '0) begin
      if (|bus.ex_in_bus[REN_LSB +: NBANK]) begin
        n_ren++;
        if (first_ren < 0) first_ren = cyc;
        last_ren = cyc;
      end
      if (exp_ex.size() == 0) bad("ex_unexpected");
      else check("ex_beat", bus.ex_in_bus, exp_ex.pop_front());
    end
    if (bus.m_valid && exp_m.size() == 0) bad("m_stale");
    else if (bus.m_valid && bus.m_ready) check("m_data", EX_IN_W'(bus.m_data), EX_IN_W'(exp_m.pop_front()));
    if (bus.done) begin
      if (exp_done.size() == 0) bad("done_unexpected");
      else chk_i("done_busy_err", int'({bus.busy, bus.err}), int'({1'b0, exp_done.pop_front()}));
    end
  end
  task automatic run_cmd(bit md, logic [7:0] base, int ln, logic [3:0] mk, int vmode, int stall, bit poke, bit seq, output int lat);
    int idx = 0, r0, s_cyc;
    model(md, base, ln, mk, seq);
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.mode = md; bus.base_addr = base; bus.len = 10'(ln); bus.bank_mask = mk;
    s_cyc = cyc; r0 = n_ren; first_ren = -1; lat = -1;
    for (int t = 0; t < 3000 && lat < 0; t++) begin
      @(posedge clk);
      #1;
      bus.start = poke && t == 3;
      bus.len = '0;
      bus.mode = !md;
      bus.s_valid = !md && idx < ln && (vmode == 0 || (vmode == 1 && t[0]) || (vmode == 2 && $urandom_range(0, 1) == 1));
      bus.s_data = (!md && idx < ln) ? wdata[idx] : '0;
      bus.m_ready = t >= stall && (vmode != 2 || $urandom_range(0, 3) != 0);
      @(negedge clk);
      #1;
      if (bus.s_valid && bus.s_ready) idx++;
      if (stall > 0 && t == stall - 1) chk_i("stall_ren_count", n_ren - r0, FIFO_DEPTH);
      if (bus.done) lat = cyc - s_cyc;
    end
    if (lat < 0) bad("timeout");
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    chk_i("ex_all_seen", exp_ex.size(), 0);
    chk_i("m_all_seen", exp_m.size(), 0);
    chk_i("done_all_seen", exp_done.size(), 0);
  endtask
  initial begin
    int lat, r0;
    bit got;
    bus.start = 1'b0; bus.mode = 1'b0; bus.base_addr = '0; bus.len = '0; bus.bank_mask = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ex_in_bus", bus.ex_in_bus, '0);
    chk_i("reset_ctrl", int'({bus.busy, bus.done, bus.err, bus.s_ready, bus.m_valid}), 0);
    check("reset_m_data", EX_IN_W'(bus.m_data), '0);
    run_cmd(1'b0, 8'h10, 8, 4'b1111, 0, 0, 1'b0, 1'b1, lat);
    chk_i("wr_full_latency", lat, 10);
    run_cmd(1'b0, 8'hFF, 4, 4'b0101, 1, 0, 1'b0, 1'b0, lat);
    run_cmd(1'b1, 8'($urandom), 8, 4'b1111, 0, 0, 1'b0, 1'b0, lat);
    chk_i("rd_ren_back_to_back", last_ren - first_ren, 7);
    run_cmd(1'b1, 8'hFE, 8, 4'b1111, 0, 20, 1'b0, 1'b0, lat);
    run_cmd(1'b0, 8'h33, 0, 4'b1111, 0, 0, 1'b0, 1'b0, lat);
    chk_i("len0_latency", lat, 2);
    run_cmd(1'b1, 8'h05, 3, 4'b0000, 0, 0, 1'b0, 1'b0, lat);
    chk_i("mask0_latency", lat, 2);
    run_cmd(1'b0, 8'($urandom), 6, 4'b1010, 0, 0, 1'b1, 1'b0, lat);
    for (int i = 0; i < 8; i++)
      run_cmd(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 12), 4'($urandom_range(1, 15)), 2, 0, 1'b0, 1'b0, lat);
    model(1'b1, 8'h40, 8, 4'b1111, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.mode = 1'b1; bus.base_addr = 8'h40; bus.len = 10'd8; bus.bank_mask = 4'b1111;
    r0 = n_ren;
    @(posedge clk);
    #1 bus.start = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      #1 got = n_ren - r0 >= 2;
    end
    if (!got) bad("rst_wait_timeout");
    rst_n = 1'b0;
    #1;
    check("async_rst_ex_in_bus", bus.ex_in_bus, '0);
    chk_i("async_rst_ctrl", int'({bus.busy, bus.done, bus.err, bus.s_ready, bus.m_valid}), 0);
    check("async_rst_m_data", EX_IN_W'(bus.m_data), '0);
    exp_ex.delete();
    exp_m.delete();
    exp_done.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_cmd(1'b0, 8'h80, 5, 4'b0110, 0, 0, 1'b0, 1'b0, lat);
    chk_i("post_rst_wr_latency", lat, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spm_ex_loader.md
Name: spm_ex_loader

Overview:
- Streaming DMA-style front end sitting directly upstream of the scratchpad's external port; sole driver of its 168-bit ex_in_bus.
- WRITE mode: converts a valid/ready word stream into per-bank write beats. READ mode: issues per-bank reads and returns the scratchpad's read data as a valid/ready stream.
- Words are distributed round-robin across the bank groups enabled in bank_mask.

Parameters:
- DATA_W, 32, per-bank data width.
- ADDR_W, 8, per-bank address width.
- NBANK, 4, bank groups; fixed by the ex_in_bus layout.
- LEN_W, 10, transfer-length counter width.
- RD_LAT, 1, scratchpad read latency in cycles (ren to data on ex_out_bus).
- FIFO_DEPTH, 4, read-return buffer depth.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- mode  in  1  0 = WRITE, 1 = READ; latched at start.
- base_addr  in  8  first per-bank address; latched at start.
- len  in  10  number of words; latched at start.
- bank_mask  in  4  enabled bank groups; latched at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of command.
- err  out  1  valid with done; 1 = command rejected.
- s_valid  in  1  write-stream valid.
- s_data  in  32  write-stream data.
- s_ready  out  1  write-stream ready.
- m_valid  out  1  read-stream valid.
- m_data  out  32  read-stream data.
- m_ready  in  1  read-stream ready.
- ex_out_bus  in  128  scratchpad read data, bank b at [32b+31:32b].
- ex_in_bus  out  168  fields: wen[167:164], ren[163:160], addr b at [128+8b+7:128+8b], data b at [32b+31:32b].

Behaviour:
- Reset values: ex_in_bus = 0, busy = 0, done = 0, err = 0, s_ready = 0, m_valid = 0, m_data = 0; FSM = IDLE; FIFO emptied.
- FSM states: IDLE, WRITE, READ, DRAIN, FIN.
- IDLE:
  - start with len != 0 and bank_mask != 0 latches the command and goes to WRITE or READ per mode.
  - start with len == 0 or bank_mask == 0 goes to FIN with err = 1; no bus activity.
  - start is ignored in every state other than IDLE.
- Beat order:
  - Beat k targets the k-th enabled bank in ascending index order, cycling through the enabled set.
  - The address starts at base_addr and increments by 1 after each full pass over the enabled banks.
  - The address wraps modulo 256 silently.
- ex_in_bus is registered. Each cycle it carries at most one active bank; all other fields are 0.
- WRITE:
  - s_ready = 1 while words remain.
  - A handshake at cycle t drives wen[b] = 1 and the addr/data fields at t+1.
  - The cycle after the final handshake goes to FIN.
- READ:
  - A ren beat is issued only if in-flight reads plus FIFO occupancy < FIFO_DEPTH.
  - A bank-tag shift register of RD_LAT stages captures ex_out_bus[bank] into the FIFO, RD_LAT cycles after ren is visible on ex_in_bus.
  - After the last ren, go to DRAIN.
- DRAIN: wait until in-flight reads = 0 and the FIFO is empty, then go to FIN.
- m_valid/m_data come from the FIFO head; pop when m_valid && m_ready. FIFO push and pop in the same cycle are legal.
- FIN: done = 1 for one cycle, busy drops the same cycle, then go to IDLE.
- busy = 1 in WRITE, READ and DRAIN.
- Reset asserted mid-command aborts immediately: all outputs return to reset values and FIFO contents are discarded.

Decomposition:
- Shared package/`define file holds: EX_in_bus width (168), field offset constants (WEN_LSB 164, REN_LSB 160, ADDR_LSB 128), and the NBANK/DATA_W/ADDR_W defaults.
- One sub-module, spm_rd_fifo: synchronous FIFO, depth FIFO_DEPTH, width 32, with count output.
- Bank selection (next enabled bank after the current one, with wrap) is a function in the top module.

Test Plan:
- WRITE, bank_mask = 4'b1111, base_addr = 8'h10, len = 8, data 1..8, s_valid held 1 → wen beats on banks 0,1,2,3,0,1,2,3 in 8 consecutive cycles; addr 0x10 ×4, then 0x11 ×4; data 1..8 in order; done one cycle after the last beat; err = 0.
- WRITE, bank_mask = 4'b0101, base_addr = 8'hFF, len = 4, s_valid toggling every cycle → banks 0,2,0,2 at addr FF, FF, 00, 00; no wen during bubbles.
- READ, bank_mask = 4'b1111, len = 8, scratchpad model returning {bank, addr}, m_ready = 1 → 8 ren beats back-to-back; m_data sequence matches beat order; done after the last m handshake.
- READ, len = 8, m_ready = 0 for 20 cycles → exactly 4 ren beats issued then stall; after m_ready = 1 the remaining 4 issue; no data lost or reordered.
- start with len = 0 → done & err = 1 two cycles later; ex_in_bus stays 0; a start pulsed while busy is ignored.
- rst asserted (low) mid-READ with 2 reads in flight → outputs 0 asynchronously; after release a new WRITE command completes normally with no stale m_valid.
